// File: rtl/fifo_packet_reader.sv
// Pop-side packet reassembler: drains FIFO words (MSB = last) and reports length/sum/overlength per packet.
// Optional overlength counter port err_cnt_o enabled by `define PKT_READER_ERR_CNT_EN.
module fifo_packet_reader #(
  parameter int  DATA_WIDTH  = 32,
  parameter int  MAX_PKT_LEN = 16,
  localparam int LW          = $clog2(MAX_PKT_LEN+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  pop_valid_i,
  input  logic [DATA_WIDTH:0]   pop_data_i,
  output logic                  pop_grant_o,
  output logic                  pkt_valid_o,
  input  logic                  pkt_ready_i,
  output logic [LW-1:0]         pkt_len_o,
  output logic [DATA_WIDTH-1:0] pkt_sum_o,
  output logic                  pkt_err_o
`ifdef PKT_READER_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, RECV, DROP, REPORT} state_t;

  state_t                state, state_nxt;
  logic [LW-1:0]         len, len_nxt;
  logic [DATA_WIDTH-1:0] sum, sum_nxt;
  logic                  err, err_nxt;
  logic                  xfer, last, hs;

  // Moore outputs: decoded from the state register only
  assign pop_grant_o = (state == RECV) || (state == DROP);
  assign pkt_valid_o = (state == REPORT);
  assign pkt_len_o   = len;
  assign pkt_sum_o   = sum;
  assign pkt_err_o   = err;

  assign xfer = pop_valid_i && pop_grant_o;
  assign last = pop_data_i[DATA_WIDTH];
  assign hs   = pkt_valid_o && pkt_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len   <= '0;
      sum   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      sum   <= sum_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    sum_nxt   = sum;
    err_nxt   = err;
    case (state)
      IDLE: if (enable_i) state_nxt = RECV;
      RECV: if (xfer) begin
        len_nxt = len + 1'b1;
        sum_nxt = sum + pop_data_i[DATA_WIDTH-1:0];
        if (last)
          state_nxt = REPORT;
        else if (len == LW'(MAX_PKT_LEN-1)) begin
          // word MAX_PKT_LEN without last: rest of packet is discarded
          state_nxt = DROP;
          err_nxt   = 1'b1;
        end
      end
      DROP: if (xfer && last) state_nxt = REPORT;
      REPORT: if (hs) begin
        len_nxt   = '0;
        sum_nxt   = '0;
        err_nxt   = 1'b0;
        state_nxt = enable_i ? RECV : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PKT_READER_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_o <= '0;
    else if (hs && err && (err_cnt_o != 16'hFFFF))
      err_cnt_o <= err_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Randomized bench for fifo_packet_reader against a packet-level model (len/sum/err from word lists).
module tb_fifo_packet_reader;
  localparam int DW  = 32;
  localparam int MAX = 16;
  localparam int LW  = $clog2(MAX+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable_i;
  logic          pop_valid_i;
  logic [DW:0]   pop_data_i;
  logic          pop_grant_o;
  logic          pkt_valid_o;
  logic          pkt_ready_i;
  logic [LW-1:0] pkt_len_o;
  logic [DW-1:0] pkt_sum_o;
  logic          pkt_err_o;
`ifdef PKT_READER_ERR_CNT_EN
  logic [15:0]   err_cnt_o;
`endif

  fifo_packet_reader #(.DATA_WIDTH(DW), .MAX_PKT_LEN(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
    .pop_valid_i(pop_valid_i), .pop_data_i(pop_data_i), .pop_grant_o(pop_grant_o),
    .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .pkt_len_o(pkt_len_o), .pkt_sum_o(pkt_sum_o), .pkt_err_o(pkt_err_o)
`ifdef PKT_READER_ERR_CNT_EN
    , .err_cnt_o(err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_ecnt = 0;
  logic [DW-1:0] wd [0:63];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one packet of n words from wd[], then handshake after rdy_dly stall cycles.
  task automatic run_pkt(input int n, input bit vtog, input int rdy_dly,
                         input bit en_mid, input bit en_after);
    int idx = 0, cyc = 0, cnt;
    logic pv, g;
    logic [DW-1:0] esum = '0;
    cnt = (n > MAX) ? MAX : n;
    for (int i = 0; i < cnt; i++) esum += wd[i];
    @(negedge clk);
    enable_i = 1'b1;
    while (idx < n && cyc < 1000) begin
      if (cyc > 0) @(negedge clk);
      if (en_mid && idx >= 1) enable_i = 1'b0;
      pv = vtog ? 1'($urandom_range(0, 1)) : 1'b1;
      pop_valid_i = pv;
      pop_data_i  = {(idx == n-1), wd[idx]};
      g = pop_grant_o;
      @(posedge clk);
      if (g && pv) idx++;
      cyc++;
    end
    if (idx < n) chk("pop_timeout", 64'(idx), 64'(n));
    @(negedge clk);
    pop_valid_i = 1'b0;
    chk("valid_lat", 64'(pkt_valid_o), 64'd1);
    chk("grant_rpt", 64'(pop_grant_o), 64'd0);
    chk("len", 64'(pkt_len_o), 64'(cnt));
    chk("sum", 64'(pkt_sum_o), 64'(esum));
    chk("err", 64'(pkt_err_o), 64'(n > MAX));
    for (int d = 0; d < rdy_dly; d++) begin
      pkt_ready_i = 1'b0;
      @(negedge clk);
      chk("stall_grant", 64'(pop_grant_o), 64'd0);
      chk("stall_valid", 64'(pkt_valid_o), 64'd1);
      chk("stall_sum", 64'({pkt_len_o, pkt_sum_o}), 64'({LW'(cnt), esum}));
    end
    enable_i = en_after;
    pkt_ready_i = 1'b1;
    @(negedge clk);
    pkt_ready_i = 1'b0;
    if (n > MAX && exp_ecnt < 16'hFFFF) exp_ecnt++;
    chk("post_grant", 64'(pop_grant_o), 64'(en_after));
    chk("post_valid", 64'(pkt_valid_o), 64'd0);
`ifdef PKT_READER_ERR_CNT_EN
    chk("err_cnt", 64'(err_cnt_o), 64'(exp_ecnt));
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 64'(pop_grant_o), 64'd0);
    chk({tag, "_valid"}, 64'(pkt_valid_o), 64'd0);
    chk({tag, "_len"},   64'(pkt_len_o), 64'd0);
    chk({tag, "_sum"},   64'(pkt_sum_o), 64'd0);
    chk({tag, "_err"},   64'(pkt_err_o), 64'd0);
`ifdef PKT_READER_ERR_CNT_EN
    chk({tag, "_ecnt"},  64'(err_cnt_o), 64'd0);
`endif
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable_i = 1'b0; pop_valid_i = 1'b0;
    pop_data_i = '0; pkt_ready_i = 1'b0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk); rst_n = 1'b1;

    wd[0] = 5; wd[1] = 7; wd[2] = 9;
    run_pkt(3, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) wd[i] = 1;
    run_pkt(16, 0, 0, 0, 1);
    run_pkt(20, 0, 0, 0, 1);
    wd[0] = 32'hFFFF_FFFF; wd[1] = 32'h2;
    run_pkt(2, 0, 5, 0, 1);
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    run_pkt(4, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    run_pkt(4, 0, 0, 1, 0);
    @(negedge clk);
    chk("idle_hold", 64'(pop_grant_o), 64'd0);

    for (int p = 0; p < 25; p++) begin
      n = $urandom_range(1, MAX + 6);
      for (int i = 0; i < n; i++) wd[i] = $urandom;
      run_pkt(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)));
    end

    // reset mid-packet: outputs drop immediately, then a fresh packet works
    @(negedge clk);
    enable_i = 1'b1; pop_valid_i = 1'b1; pop_data_i = {1'b0, 32'd3};
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_ecnt = 0;
    chk_reset_vals("midrst");
    @(negedge clk);
    pop_valid_i = 1'b0; rst_n = 1'b1;
    wd[0] = 11; wd[1] = 22;
    run_pkt(2, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
